// File: rtl/haptic_pkg.sv
// Shared definitions for the APB haptic driver: register word offsets,
// CTRL/STATUS bit positions and the burst FSM state encoding.
package haptic_pkg;

    // Word index taken from PADDR[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_ON_T   = 3'd1;
    localparam logic [2:0] REG_OFF_T  = 3'd2;
    localparam logic [2:0] REG_BURST  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_IRQEN  = 3'd5;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_REM_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

endpackage

// File: rtl/haptic_timer.sv
// Phase timer: loads max(value,1), counts down to 1 and flags expiry on the
// last cycle of the phase; shared by the ON and OFF phases of a pulse.
module haptic_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = (val_i == '0) ? CNT_W'(1) : val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_haptic_driver.sv
// APB3 slave that drives the vibration motor with timed ON/OFF pulse bursts.
// Define HAPTIC_IRQ_EN to add the IRQEN register and the burst-done interrupt.
module apb_haptic_driver
    import haptic_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int BURST_W = 8
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        motor,
    output logic        irq
);

    state_e               state_q, state_d;
    logic                 en_q, en_d, cont_q, cont_d, done_q, done_d;
    logic [CNT_W-1:0]     on_t_q, on_t_d, off_t_q, off_t_d;
    logic [CNT_W-1:0]     sh_on_q, sh_on_d, sh_off_q, sh_off_d;
    logic [BURST_W-1:0]   burst_q, burst_d, sh_burst_q, sh_burst_d, rem_q, rem_d;
    logic                 tmr_load, tmr_clr, tmr_expire;
    logic [CNT_W-1:0]     tmr_val;
    logic [31:0]          rdata;
`ifdef HAPTIC_IRQ_EN
    logic                 irqen_q, irqen_d;
`endif

    wire [2:0] reg_idx   = PADDR[4:2];
    wire       wr_en     = PSEL & PENABLE & PWRITE;
    wire       wr_ctrl   = wr_en && (reg_idx == REG_CTRL);
    // Clearing EN through a CTRL write aborts a burst exactly like STOP.
    wire       stop_req  = wr_ctrl & (PWDATA[CTRL_STOP] | ~PWDATA[CTRL_EN]);
    wire       start_req = wr_ctrl & PWDATA[CTRL_START] & PWDATA[CTRL_EN] & ~PWDATA[CTRL_STOP];

    wire       unused_apb = ^{PADDR[31:5], PADDR[1:0], PWDATA};

    function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] b);
        return (b == '0) ? BURST_W'(1) : b;
    endfunction

    haptic_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (PCLK),
        .rst_n    (PRESERN),
        .clr_i    (tmr_clr),
        .load_i   (tmr_load),
        .val_i    (tmr_val),
        .expire_o (tmr_expire)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        cont_d     = cont_q;
        done_d     = done_q;
        on_t_d     = on_t_q;
        off_t_d    = off_t_q;
        burst_d    = burst_q;
        sh_on_d    = sh_on_q;
        sh_off_d   = sh_off_q;
        sh_burst_d = sh_burst_q;
        rem_d      = rem_q;
        tmr_load   = 1'b0;
        tmr_clr    = 1'b0;
        tmr_val    = sh_on_q;
`ifdef HAPTIC_IRQ_EN
        irqen_d    = irqen_q;
`endif

        if (wr_en) begin
            case (reg_idx)
                REG_CTRL: begin
                    en_d   = PWDATA[CTRL_EN];
                    cont_d = PWDATA[CTRL_CONT];
                end
                REG_ON_T:   on_t_d  = PWDATA[CNT_W-1:0];
                REG_OFF_T:  off_t_d = PWDATA[CNT_W-1:0];
                REG_BURST:  burst_d = PWDATA[BURST_W-1:0];
                REG_STATUS: if (PWDATA[STAT_DONE]) done_d = 1'b0;
`ifdef HAPTIC_IRQ_EN
                REG_IRQEN:  irqen_d = PWDATA[0];
`endif
                default: ;
            endcase
        end

        if ((state_q != ST_IDLE) && stop_req) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        sh_on_d    = on_t_q;
                        sh_off_d   = off_t_q;
                        sh_burst_d = burst_q;
                        rem_d      = burst_len(burst_q);
                        done_d     = 1'b0;
                        state_d    = ST_ON;
                        tmr_load   = 1'b1;
                        tmr_val    = on_t_q;
                    end
                end
                ST_ON: begin
                    if (tmr_expire) begin
                        state_d  = ST_OFF;
                        tmr_load = 1'b1;
                        tmr_val  = sh_off_q;
                    end
                end
                ST_OFF: begin
                    if (tmr_expire) begin
                        if (rem_q == BURST_W'(1) && !cont_q) begin
                            rem_d   = '0;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rem_d    = (rem_q == BURST_W'(1)) ? burst_len(sh_burst_q)
                                                              : rem_q - BURST_W'(1);
                            state_d  = ST_ON;
                            tmr_load = 1'b1;
                            tmr_val  = sh_on_q;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            cont_q     <= 1'b0;
            done_q     <= 1'b0;
            on_t_q     <= '0;
            off_t_q    <= '0;
            burst_q    <= '0;
            sh_on_q    <= '0;
            sh_off_q   <= '0;
            sh_burst_q <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            cont_q     <= cont_d;
            done_q     <= done_d;
            on_t_q     <= on_t_d;
            off_t_q    <= off_t_d;
            burst_q    <= burst_d;
            sh_on_q    <= sh_on_d;
            sh_off_q   <= sh_off_d;
            sh_burst_q <= sh_burst_d;
            rem_q      <= rem_d;
        end
    end

`ifdef HAPTIC_IRQ_EN
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            irqen_q <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
        end
    end

    assign irq = done_q & irqen_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (PSEL && !PWRITE) begin
            case (reg_idx)
                REG_CTRL: begin
                    rdata[CTRL_EN]   = en_q;
                    rdata[CTRL_CONT] = cont_q;
                end
                REG_ON_T:  rdata[CNT_W-1:0]   = on_t_q;
                REG_OFF_T: rdata[CNT_W-1:0]   = off_t_q;
                REG_BURST: rdata[BURST_W-1:0] = burst_q;
                REG_STATUS: begin
                    rdata[STAT_BUSY]               = (state_q != ST_IDLE);
                    rdata[STAT_DONE]               = done_q;
                    rdata[STAT_REM_LSB +: BURST_W] = rem_q;
                end
`ifdef HAPTIC_IRQ_EN
                REG_IRQEN: rdata[0] = irqen_q;
`endif
                default: ;
            endcase
        end
    end

    assign PRDATA  = rdata;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign motor   = (state_q == ST_ON);

endmodule

// File: tb/tb_apb_haptic_driver.sv
// Scoreboard bench for apb_haptic_driver: stimulus pushes expected read data and
// per-cycle motor/irq values; a negedge monitor pops and compares them.
module tb_apb_haptic_driver;

`ifdef HAPTIC_IRQ_EN
    localparam logic IRQ_BUILD = 1'b1;
`else
    localparam logic IRQ_BUILD = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESERN, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR, motor, irq;

    apb_haptic_driver dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .motor   (motor),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int   cyc;
        logic motor;
        logic irq;
    } pin_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } rd_t;

    pin_t pin_q[$];
    rd_t  rd_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   stim_done = 1'b0;
    bit   mon_done = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        pin_t it;
        rd_t  r;
        while (pin_q.size() > 0 && pin_q[0].cyc <= cyc) begin
            it = pin_q.pop_front();
            n_vec++;
            if (it.cyc != cyc || motor !== it.motor || irq !== it.irq) begin
                n_err++;
                $display("FAIL pins cyc %0d (due %0d): got motor=%b irq=%b, expected motor=%b irq=%b",
                         cyc, it.cyc, motor, irq, it.motor, it.irq);
            end
        end
        if (PSEL && PENABLE && !PWRITE) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL read %h: unexpected read, got %h", PADDR, PRDATA);
            end else begin
                r = rd_q.pop_front();
                if (PRDATA !== r.data || PADDR !== r.addr) begin
                    n_err++;
                    $display("FAIL read %h: got %h, expected %h (addr %h)", PADDR, PRDATA, r.data, r.addr);
                end
            end
            n_vec++;
            if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
                n_err++;
                $display("FAIL apb_resp %h: got PREADY=%b PSLVERR=%b, expected 1/0", PADDR, PREADY, PSLVERR);
            end
        end
        if (stim_done && !mon_done) begin
            n_vec++;
            if (pin_q.size() != 0 || rd_q.size() != 0) begin
                n_err++;
                $display("FAIL leftover: %0d pin and %0d read expectations never checked, expected 0",
                         pin_q.size(), rd_q.size());
            end
            mon_done = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) idle(1);
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] exp);
        rd_q.push_back('{a, exp});
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Push n motor values, MSB of bits first, starting at cycle c0.
    task automatic push_bits(input int c0, input logic [31:0] bits, input int n, input logic irq_e);
        for (int i = 0; i < n; i++) pin_q.push_back('{c0 + i, bits[n-1-i], irq_e});
    endtask

    task automatic push_const(input int c0, input logic m, input int n, input logic irq_e);
        for (int i = 0; i < n; i++) pin_q.push_back('{c0 + i, m, irq_e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;

        // Reset state
        push_const(1, 1'b0, 3, 1'b0);
        idle(4);
        PRESERN = 1'b1;
        idle(1);
        apb_read(32'h00, 32'h0);
        apb_read(32'h04, 32'h0);
        apb_read(32'h08, 32'h0);
        apb_read(32'h0C, 32'h0);
        apb_read(32'h10, 32'h0);

        // ON_T=3, OFF_T=2, BURST=2
        apb_write(32'h04, 3);
        apb_write(32'h08, 2);
        apb_write(32'h0C, 2);
        apb_write(32'h00, 32'h5);
        c = cyc;
        push_bits(c, 32'b1110011100, 10, 1'b0);
        push_const(c + 10, 1'b0, 2, 1'b0);
        wait_until(c + 12);
        apb_read(32'h10, 32'h2);
        apb_read(32'h00, 32'h1);
        apb_write(32'h10, 32'h2);
        apb_read(32'h10, 32'h0);

        // Zero times, zero burst: single 1-cycle pulse
        apb_write(32'h04, 0);
        apb_write(32'h08, 0);
        apb_write(32'h0C, 0);
        apb_write(32'h00, 32'h5);
        c = cyc;
        push_bits(c, 32'b1000, 4, 1'b0);
        wait_until(c + 4);
        apb_read(32'h10, 32'h2);

        // Continuous mode, 5 pulses then STOP
        apb_write(32'h04, 4);
        apb_write(32'h08, 4);
        apb_write(32'h0C, 1);
        apb_write(32'h00, 32'h7);
        c = cyc;
        for (int p = 0; p < 5; p++) push_bits(c + 8 * p, 32'b11110000, 8, 1'b0);
        push_const(c + 40, 1'b0, 4, 1'b0);
        idle(19);
        apb_read(32'h10, 32'h101);
        wait_until(c + 38);
        apb_write(32'h00, 32'hB);
        wait_until(c + 44);
        apb_read(32'h10, 32'h0);
        apb_read(32'h00, 32'h3);

        // Mid-burst ON_T write uses shadow; next START uses the new value
        apb_write(32'h00, 32'h1);
        apb_write(32'h04, 3);
        apb_write(32'h08, 2);
        apb_write(32'h0C, 3);
        apb_write(32'h00, 32'h5);
        c = cyc;
        for (int p = 0; p < 3; p++) push_bits(c + 5 * p, 32'b11100, 5, 1'b0);
        push_const(c + 15, 1'b0, 2, 1'b0);
        apb_write(32'h04, 10);
        wait_until(c + 17);
        apb_read(32'h10, 32'h2);
        apb_read(32'h04, 32'd10);
        apb_write(32'h10, 32'h2);
        apb_write(32'h08, 0);
        apb_write(32'h0C, 1);
        apb_write(32'h00, 32'h5);
        c = cyc;
        push_bits(c, 32'h3FF, 10, 1'b0);
        push_const(c + 10, 1'b0, 2, 1'b0);
        apb_write(32'h00, 32'h5);
        wait_until(c + 12);
        apb_read(32'h10, 32'h2);

        // START with EN=0, unmapped reads
        apb_write(32'h00, 32'h4);
        c = cyc;
        push_const(c, 1'b0, 5, 1'b0);
        wait_until(c + 5);
        apb_read(32'h10, 32'h2);
        apb_read(32'h00, 32'h0);
        apb_read(32'h18, 32'h0);
        apb_read(32'h14, 32'h0);
        apb_read(32'h1C, 32'h0);

        // STOP and START together: STOP wins
        apb_write(32'h00, 32'hD);
        c = cyc;
        push_const(c, 1'b0, 4, 1'b0);
        wait_until(c + 4);
        apb_read(32'h10, 32'h2);
        apb_read(32'h00, 32'h1);

        // EN cleared mid-burst
        apb_write(32'h04, 5);
        apb_write(32'h08, 5);
        apb_write(32'h0C, 4);
        apb_write(32'h00, 32'h5);
        c = cyc;
        push_const(c, 1'b1, 2, 1'b0);
        push_const(c + 2, 1'b0, 3, 1'b0);
        apb_write(32'h00, 32'h0);
        wait_until(c + 5);
        apb_read(32'h10, 32'h0);
        apb_read(32'h00, 32'h0);

        // Asynchronous reset mid-burst
        apb_write(32'h00, 32'h5);
        c = cyc;
        push_const(c, 1'b1, 1, 1'b0);
        push_const(c + 1, 1'b0, 2, 1'b0);
        idle(1);
        PRESERN = 1'b0;
        idle(2);
        PRESERN = 1'b1;
        idle(1);
        apb_read(32'h10, 32'h0);
        apb_read(32'h04, 32'h0);
        apb_read(32'h00, 32'h0);

        // IRQEN and burst-done interrupt (tied 0 without HAPTIC_IRQ_EN)
        apb_write(32'h14, 32'h1);
        apb_read(32'h14, {31'b0, IRQ_BUILD});
        apb_write(32'h00, 32'h5);
        c = cyc;
        pin_q.push_back('{c,     1'b1, 1'b0});
        pin_q.push_back('{c + 1, 1'b0, 1'b0});
        pin_q.push_back('{c + 2, 1'b0, IRQ_BUILD});
        pin_q.push_back('{c + 3, 1'b0, IRQ_BUILD});
        pin_q.push_back('{c + 4, 1'b0, 1'b0});
        pin_q.push_back('{c + 5, 1'b0, 1'b0});
        idle(2);
        apb_write(32'h10, 32'h2);
        wait_until(c + 6);
        apb_read(32'h10, 32'h0);

        idle(2);
        stim_done = 1'b1;
        wait (mon_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
